// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a length-prefixed, XOR-checksummed
// byte stream into 32-bit word writes and releases the core only after a verified image.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err
);

    // Handshake: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready depends only on state, never on in_valid.
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [23:0] shreg;
    logic        we_q;
    logic        xfer;
    logic        last_word;
    logic [16:0] n_full;

    always_comb begin
        state_nxt = state;
        in_ready  = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
        xfer      = in_valid && in_ready;
        n_full    = {1'b0, in_data, n_lo};
        last_word = ((word_cnt + 16'd1) == n_words);
        case (state)
            HDR0: if (xfer) state_nxt = HDR1;
            HDR1: if (xfer) begin
                if (n_full > MAX_N)       state_nxt = ERR;
                else if (n_full == 17'd0) state_nxt = CSUM;
                else                      state_nxt = DATA;
            end
            DATA: if (xfer && (byte_cnt == 2'd3) && last_word) state_nxt = CSUM;
            CSUM: if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
            default: state_nxt = state;
        endcase
        core_rst = (state != DONE);
        done     = (state == DONE);
        err      = (state == ERR);
        // A write registered just before reset must not reach the memory.
        imem_we  = we_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HDR0;
            n_lo       <= '0;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            shreg      <= '0;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state <= state_nxt;
            we_q  <= 1'b0;
            if (xfer) begin
                case (state)
                    HDR0: n_lo    <= in_data;
                    HDR1: n_words <= {in_data, n_lo};
                    DATA: begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: shreg[7:0]   <= in_data;
                            2'd1: shreg[15:8]  <= in_data;
                            2'd2: shreg[23:16] <= in_data;
                            default: begin
                                imem_wdata <= {in_data, shreg};
                                imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                                we_q       <= 1'b1;
                                word_cnt   <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
